// File: rtl/corefifo_gray_bin_pipe.sv
// corefifo_gray_bin_pipe: pipelined gray<->binary converter with valid/ready stages
// and an optional checker flagging gray steps that flip more than one bit.
module corefifo_gray_bin_pipe #(
   parameter int ADDRWIDTH = 3,
   parameter int STAGES = 2,
   parameter int MODE = 0,
   parameter int CHECK_EN = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic [ADDRWIDTH:0] in_data,
   input  logic in_valid,
   output logic in_ready,
   output logic [ADDRWIDTH:0] out_data,
   output logic out_valid,
   input  logic out_ready,
   output logic step_err
);
   localparam int W = ADDRWIDTH + 1;
   localparam int SEG = (W + STAGES - 1) / STAGES;
   logic [ADDRWIDTH:0] last_gray, diff;
   logic first, err;
   assign diff = in_data ^ last_gray;
   // x & (x-1) is nonzero exactly when more than one bit of x is set
   assign err = CHECK_EN == 1 && MODE == 0 && !first && ((diff & (diff - W'(1))) != '0);
   always_ff @(posedge clk)
      if (reset) begin
         last_gray <= '0;
         first <= 1'b1;
      end else if (in_valid && in_ready) begin
         last_gray <= in_data;
         first <= 1'b0;
      end
   for (genvar k = 0; k < STAGES; k++) begin : st
      localparam int HI = W - 1 - k * SEG;
      localparam int LO = W - (k + 1) * SEG > 0 ? W - (k + 1) * SEG : 0;
      logic [ADDRWIDTH:0] sg, sr, nr, t, r;
      logic sv, se, dn, ld, v, e;
      if (k == 0) begin : src
         assign sg = in_data;
         assign sr = MODE == 1 ? in_data ^ (in_data >> 1) : '0;
         assign sv = in_valid;
         assign se = err;
      end else begin : src
         assign sg = st[k-1].gw.g;
         assign sr = st[k-1].r;
         assign sv = st[k-1].v;
         assign se = st[k-1].e;
      end
      if (k == STAGES - 1) begin : dnl
         assign dn = out_ready;
      end else begin : dnl
         assign dn = st[k+1].ld;
      end
      // the raw gray word is only needed by a following stage
      if (k < STAGES - 1) begin : gw
         logic [ADDRWIDTH:0] g;
         always_ff @(posedge clk)
            if (reset) g <= '0;
            else if (ld) g <= sg;
      end
      assign ld = !v || dn;
      always_comb begin
         nr = sr;
         t = '0;
         if (MODE == 0)
            for (int i = W - 1; i >= 0; i--)
               if (i >= LO && i <= HI) begin
                  t = nr >> 1;
                  nr[i] = sg[i] ^ t[i];
               end
      end
      always_ff @(posedge clk)
         if (reset) begin
            v <= 1'b0;
            e <= 1'b0;
            r <= '0;
         end else if (ld) begin
            v <= sv;
            e <= sv && se;
            r <= nr;
         end
   end
   assign in_ready = !reset && st[0].ld;
   assign out_valid = st[STAGES-1].v;
   assign out_data = st[STAGES-1].r;
   assign step_err = st[STAGES-1].e;
endmodule

// File: tb/tb_corefifo_gray_bin_pipe.sv
// tb_corefifo_gray_bin_pipe: directed table/corner sequences plus randomized
// handshake streams checked against a queue-based reference model.
module tb_corefifo_gray_bin_pipe;
   typedef struct {
      logic [3:0] g;
      logic [3:0] b;
      logic e;
   } vec_t;
   logic clk;
   int checks = 0;
   int errors = 0;
   vec_t v[20];
   logic [3:0] gl[17];
   logic ra, iva, ira, ova, ora, sea;
   logic [3:0] ida, oda;
   logic rb, ivb, irb, ovb, orb, seb;
   logic [3:0] idb, odb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   corefifo_gray_bin_pipe u_a (.clk(clk), .reset(ra), .in_data(ida), .in_valid(iva), .in_ready(ira),
      .out_data(oda), .out_valid(ova), .out_ready(ora), .step_err(sea));
   corefifo_gray_bin_pipe #(.MODE(1), .STAGES(3)) u_b (.clk(clk), .reset(rb), .in_data(idb),
      .in_valid(ivb), .in_ready(irb), .out_data(odb), .out_valid(ovb), .out_ready(orb), .step_err(seb));

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic int g2b(input int g);
      int b = g;
      for (int sh = 1; sh < 32; sh = sh * 2) b = b ^ (b >> sh);
      return b;
   endfunction

   function automatic int b2g(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic reset_a();
      @(negedge clk);
      ra = 1; iva = 1; ida = 4'hF; ora = 1;
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(ira), 0);
      chk("rst_out_valid", 32'(ova), 0);
      chk("rst_out_data", 32'(oda), 0);
      chk("rst_step_err", 32'(sea), 0);
      @(negedge clk);
      ra = 0; iva = 0; #1;
      chk("post_rst_in_ready", 32'(ira), 1);
      chk("post_rst_out_valid", 32'(ova), 0);
   endtask

   task automatic stream(input int st, input int n);
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         ora = 1;
         iva = i < n;
         if (i < n) ida = v[st+i].g;
         #1;
         if (i < n) chk("s_in_ready", 32'(ira), 1);
         if (i >= 2) begin
            chk("s_out_valid", 32'(ova), 1);
            chk("s_out_data", 32'(oda), 32'(v[st+i-2].b));
            chk("s_step_err", 32'(sea), 32'(v[st+i-2].e));
         end else chk("s_early_valid", 32'(ova), 0);
      end
      iva = 0;
   endtask

   for (genvar s = 0; s < 4; s++) begin : rnd
      logic rs, iv, ir, ov, orr, se;
      logic [4:0] id, od;
      bit fin;
      int qb[$], qe[$], qt[$];
      corefifo_gray_bin_pipe #(.ADDRWIDTH(4), .STAGES(s + 1)) dut (.clk(clk), .reset(rs), .in_data(id),
         .in_valid(iv), .in_ready(ir), .out_data(od), .out_valid(ov), .out_ready(orr), .step_err(se));
      initial begin
         int cyc, nacc, nout, lastg, lastd, x;
         bit frst;
         fin = 0; rs = 1; iv = 0; id = 0; orr = 0;
         cyc = 0; nacc = 0; nout = 0; lastg = 0; lastd = 0; frst = 1;
         repeat (3) @(negedge clk);
         rs = 0;
         while (nout < 2500 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            iv = nacc < 2500 && $urandom_range(3) != 0;
            orr = $urandom_range(3) != 0;
            x = $urandom_range(3);
            if (x == 0) id = 5'(lastd);
            else if (x == 1) id = 5'($urandom);
            else id = 5'(b2g((g2b(lastd) + 1) % 32));
            lastd = int'(id);
            #1;
            if (ov && orr) begin
               if (qb.size() == 0) chk("rnd_extra_out", 32'(ov), 0);
               else begin
                  chk("rnd_data", 32'(od), 32'(qb.pop_front()));
                  chk("rnd_err", 32'(se), 32'(qe.pop_front()));
                  chk("rnd_latency", 32'(cyc - qt.pop_front() >= s + 1), 1);
                  nout++;
               end
            end
            if (iv && ir) begin
               qb.push_back(g2b(int'(id)));
               qe.push_back(int'(!frst && $countones(int'(id) ^ lastg) > 1));
               qt.push_back(cyc);
               lastg = int'(id);
               frst = 0;
               nacc++;
            end
         end
         chk("rnd_no_timeout", 32'(cyc < 40000), 1);
         chk("rnd_count", 32'(nout), 32'(nacc));
         iv = 0; orr = 1;
         repeat (6) begin
            @(negedge clk); #1;
            chk("rnd_drained", 32'(ov), 0);
         end
         fin = 1;
      end
   end

   initial begin
      gl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      for (int i = 0; i < 17; i++) v[i] = '{g: gl[i], b: 4'(i % 16), e: 1'b0};
      v[17] = '{g: 4'h0, b: 4'h0, e: 1'b0};
      v[18] = '{g: 4'h5, b: 4'h6, e: 1'b1};
      v[19] = '{g: 4'h4, b: 4'h7, e: 1'b0};
      ra = 1; iva = 0; ida = 0; ora = 1;
      rb = 1; ivb = 0; idb = 0; orb = 1;
      repeat (2) @(negedge clk);
      rb = 0;
      reset_a();
      stream(0, 17);
      reset_a();
      stream(17, 3);
      // backpressure: two words fill the 2-stage pipe, a third waits
      reset_a();
      @(negedge clk);
      ora = 0; iva = 1; ida = 4'h3; #1;
      chk("bp_ready0", 32'(ira), 1);
      @(negedge clk);
      ida = 4'h2; #1;
      chk("bp_ready1", 32'(ira), 1);
      @(negedge clk);
      ida = 4'h6;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk("bp_full_ready", 32'(ira), 0);
         chk("bp_hold_valid", 32'(ova), 1);
         chk("bp_hold_data", 32'(oda), 2);
         chk("bp_hold_err", 32'(sea), 0);
         @(negedge clk);
      end
      ora = 1; #1;
      chk("bp_rel_ready", 32'(ira), 1);
      chk("bp_out0", 32'(oda), 2);
      chk("bp_val0", 32'(ova), 1);
      @(negedge clk);
      iva = 0; #1;
      chk("bp_out1", 32'(oda), 3);
      chk("bp_val1", 32'(ova), 1);
      @(negedge clk); #1;
      chk("bp_out2", 32'(oda), 4);
      chk("bp_val2", 32'(ova), 1);
      @(negedge clk); #1;
      chk("bp_empty", 32'(ova), 0);
      // reset with two words in flight
      @(negedge clk);
      iva = 1; ida = 4'h1;
      @(negedge clk);
      ida = 4'h3;
      @(negedge clk);
      iva = 0; ra = 1; #1;
      chk("mid_inflight", 32'(ova), 1);
      @(negedge clk); #1;
      chk("mid_rst_valid", 32'(ova), 0);
      chk("mid_rst_ready", 32'(ira), 0);
      @(negedge clk);
      ra = 0; #1;
      chk("mid_post_ready", 32'(ira), 1);
      chk("mid_post_valid", 32'(ova), 0);
      iva = 1; ida = 4'hF;
      @(negedge clk);
      iva = 0; #1;
      chk("mid_lat1", 32'(ova), 0);
      @(negedge clk); #1;
      chk("mid_out_valid", 32'(ova), 1);
      chk("mid_out_data", 32'(oda), 32'hA);
      chk("mid_out_err", 32'(sea), 0);
      @(negedge clk); #1;
      chk("mid_done", 32'(ova), 0);
      // binary-to-gray, three stages
      @(negedge clk);
      ivb = 1; idb = 4'hB; orb = 1; #1;
      chk("b2g_ready", 32'(irb), 1);
      @(negedge clk);
      ivb = 0; #1;
      chk("b2g_lat1", 32'(ovb), 0);
      @(negedge clk); #1;
      chk("b2g_lat2", 32'(ovb), 0);
      @(negedge clk); #1;
      chk("b2g_valid", 32'(ovb), 1);
      chk("b2g_data", 32'(odb), 32'hE);
      chk("b2g_err", 32'(seb), 0);
      for (int i = 0; i < 60000 && !(rnd[0].fin && rnd[1].fin && rnd[2].fin && rnd[3].fin); i++)
         @(negedge clk);
      chk("rnd_all_done", 32'(rnd[0].fin && rnd[1].fin && rnd[2].fin && rnd[3].fin), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
